// File: rtl/bus_trace_checker.sv
// ----------------------------------------------------------------------------
// bus_trace_checker
//
// Stands on the CPU memory bus in place of memory and compares each CPU
// access against an expected transaction stream. Expected entries are pushed
// through a valid/ready port into an internal FIFO. The FIFO head supplies
// read data for reads and the reference address/data for writes. The block
// counts good transactions and errors, and it captures the details of the
// first error.
//
// Ports:
//   clock, reset         system clock, asynchronous active-low reset
//   clear                synchronous flush of FIFO, counters, capture, state
//   exp_valid/exp_ready  push handshake for expected entries
//   exp_is_write         expected kind (1 = write, 0 = read)
//   exp_addr, exp_data   expected address, and write data to check or read
//                        data to serve
//   address_bus, data_in CPU address and CPU write data
//   data_out, data_oe    read data to the CPU and its drive enable
//   nread, nwrite, nsel  active-low CPU strobes
//   match_count          checked-good transactions (saturating)
//   error_count          errors (saturating)
//   halted               checker stopped on error
//   err_code             first error: 0 none, 1 addr, 2 data, 3 kind,
//                        4 underflow, 5 both strobes
//   err_index            match_count + error_count when the first error hit
//   err_exp_*/err_got_*  expected/received address and data of first error
//
// State table:
//   state   | meaning
//   IDLE    | waiting for a strobe; head is checked on the first active cycle
//   ACCESS  | strobe still active; already checked, pop when it drops
//   HALTED  | stopped on error; no checks, no pops, no read drive
// ----------------------------------------------------------------------------
module bus_trace_checker #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 16,
    parameter int CNT_W         = 24,
    parameter int STOP_ON_ERROR = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,

    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic              exp_is_write,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,

    input  logic [ADDR_W-1:0] address_bus,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic              nread,
    input  logic              nwrite,
    input  logic              nsel,

    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  error_count,
    output logic              halted,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  err_index,
    output logic [ADDR_W-1:0] err_exp_addr,
    output logic [ADDR_W-1:0] err_got_addr,
    output logic [DATA_W-1:0] err_exp_data,
    output logic [DATA_W-1:0] err_got_data
);

    localparam int PTR_W = $clog2(DEPTH);

    // DEPTH is a power of two, so a full FIFO has only the top count bit set.
    localparam logic [PTR_W:0] FULL_COUNT = {1'b1, {PTR_W{1'b0}}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_ADDR  = 3'd1;
    localparam logic [2:0] CODE_DATA  = 3'd2;
    localparam logic [2:0] CODE_KIND  = 3'd3;
    localparam logic [2:0] CODE_UFLOW = 3'd4;
    localparam logic [2:0] CODE_BOTH  = 3'd5;

    // ------------------------------------------------------------------
    // Expected-transaction FIFO
    // ------------------------------------------------------------------
    logic              mem_kind [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic              head_kind;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign full      = (fifo_count == FULL_COUNT);
    assign empty     = (fifo_count == '0);
    assign exp_ready = !full;
    assign push      = exp_valid && exp_ready;

    assign head_kind = mem_kind[rd_ptr];
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Storage carries no reset; its contents are only visible while the
    // FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem_kind[wr_ptr] <= exp_is_write;
            mem_addr[wr_ptr] <= exp_addr;
            mem_data[wr_ptr] <= exp_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus decode and head check
    // ------------------------------------------------------------------
    logic       rd;
    logic       wr;
    logic       act;
    logic [2:0] chk_code;

    assign rd  = !nsel && !nread;
    assign wr  = !nsel && !nwrite;
    assign act = rd || wr;

    always_comb begin
        chk_code = CODE_NONE;
        if (rd && wr) begin
            chk_code = CODE_BOTH;
        end else if (empty) begin
            chk_code = CODE_UFLOW;
        end else if (head_kind != wr) begin
            chk_code = CODE_KIND;
        end else if (address_bus != head_addr) begin
            chk_code = CODE_ADDR;
        end else if (wr && (data_in != head_data)) begin
            chk_code = CODE_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Access FSM, statistics and first-error capture
    // ------------------------------------------------------------------
    logic [1:0] state;
    // Set when the access began with a head entry to consume; an underflowed
    // access must not pop whatever was pushed while it was in progress.
    logic       had_entry;

    assign pop    = (state == ST_ACCESS) && !act && had_entry;
    assign halted = (state == ST_HALTED);

    assign data_out = empty ? '0 : head_data;
    assign data_oe  = rd && !wr && !empty && !head_kind && (state != ST_HALTED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            had_entry    <= 1'b0;
            match_count  <= '0;
            error_count  <= '0;
            err_code     <= CODE_NONE;
            err_index    <= '0;
            err_exp_addr <= '0;
            err_got_addr <= '0;
            err_exp_data <= '0;
            err_got_data <= '0;
        end else if (clear) begin
            state        <= ST_IDLE;
            had_entry    <= 1'b0;
            match_count  <= '0;
            error_count  <= '0;
            err_code     <= CODE_NONE;
            err_index    <= '0;
            err_exp_addr <= '0;
            err_got_addr <= '0;
            err_exp_data <= '0;
            err_got_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (act) begin
                        had_entry <= !empty;
                        if (chk_code == CODE_NONE) begin
                            if (match_count != '1) begin
                                match_count <= match_count + CNT_W'(1);
                            end
                            state <= ST_ACCESS;
                        end else begin
                            if (error_count != '1) begin
                                error_count <= error_count + CNT_W'(1);
                            end
                            if (err_code == CODE_NONE) begin
                                err_code     <= chk_code;
                                err_index    <= match_count + error_count;
                                err_exp_addr <= empty ? '0 : head_addr;
                                err_got_addr <= address_bus;
                                err_exp_data <= empty ? '0 : head_data;
                                err_got_data <= data_in;
                            end
                            state <= (STOP_ON_ERROR != 0) ? ST_HALTED : ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!act) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_trace_checker.sv
// ----------------------------------------------------------------------------
// tb_bus_trace_checker
//
// Two checkers share one set of inputs: dut_s stops on the first error, and
// dut_c counts errors and carries on. Both have a four-entry FIFO. Read data
// is scoreboarded: each cycle in which a checker should drive the bus, the
// expected byte is queued for that checker, and a negedge monitor pops and
// compares whenever data_oe is high. Status outputs are compared against
// hand-computed values after each step.
// ----------------------------------------------------------------------------
module tb_bus_trace_checker;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        exp_valid;
    logic        exp_is_write;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic [15:0] address_bus;
    logic [7:0]  data_in;
    logic        nread;
    logic        nwrite;
    logic        nsel;

    logic        ready_s, ready_c;
    logic [7:0]  data_out_s, data_out_c;
    logic        oe_s, oe_c;
    logic [23:0] match_s, match_c;
    logic [23:0] err_s, err_c;
    logic        halted_s, halted_c;
    logic [2:0]  code_s, code_c;
    logic [23:0] idx_s, idx_c;
    logic [15:0] eaddr_s, eaddr_c, gaddr_s, gaddr_c;
    logic [7:0]  edata_s, edata_c, gdata_s, gdata_c;

    int errors = 0;
    int checks = 0;

    logic [7:0] q_s[$];
    logic [7:0] q_c[$];
    logic [7:0] mon_exp;

    bus_trace_checker #(.ADDR_W(16), .DATA_W(8), .DEPTH(4), .CNT_W(24), .STOP_ON_ERROR(1)) dut_s (
        .clock(clock), .reset(reset), .clear(clear),
        .exp_valid(exp_valid), .exp_ready(ready_s), .exp_is_write(exp_is_write),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .address_bus(address_bus), .data_in(data_in),
        .data_out(data_out_s), .data_oe(oe_s),
        .nread(nread), .nwrite(nwrite), .nsel(nsel),
        .match_count(match_s), .error_count(err_s), .halted(halted_s),
        .err_code(code_s), .err_index(idx_s),
        .err_exp_addr(eaddr_s), .err_got_addr(gaddr_s),
        .err_exp_data(edata_s), .err_got_data(gdata_s)
    );

    bus_trace_checker #(.ADDR_W(16), .DATA_W(8), .DEPTH(4), .CNT_W(24), .STOP_ON_ERROR(0)) dut_c (
        .clock(clock), .reset(reset), .clear(clear),
        .exp_valid(exp_valid), .exp_ready(ready_c), .exp_is_write(exp_is_write),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .address_bus(address_bus), .data_in(data_in),
        .data_out(data_out_c), .data_oe(oe_c),
        .nread(nread), .nwrite(nwrite), .nsel(nsel),
        .match_count(match_c), .error_count(err_c), .halted(halted_c),
        .err_code(code_c), .err_index(idx_c),
        .err_exp_addr(eaddr_c), .err_got_addr(gaddr_c),
        .err_exp_data(edata_c), .err_got_data(gdata_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Read-data scoreboard monitor
    always @(negedge clock) begin
        if (oe_s === 1'b1) begin
            checks++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL rd_s: unexpected data_oe, data_out=0x%0h", data_out_s);
            end else begin
                mon_exp = q_s.pop_front();
                if (data_out_s !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_s: data_out=0x%0h expected 0x%0h", data_out_s, mon_exp);
                end
            end
        end
        if (oe_c === 1'b1) begin
            checks++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL rd_c: unexpected data_oe, data_out=0x%0h", data_out_c);
            end else begin
                mon_exp = q_c.pop_front();
                if (data_out_c !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_c: data_out=0x%0h expected 0x%0h", data_out_c, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic stat_s(input string n, input int m, input int e, input int h, input int code);
        check({n, " s.match"},  32'(match_s),  32'(m));
        check({n, " s.errors"}, 32'(err_s),    32'(e));
        check({n, " s.halted"}, 32'(halted_s), 32'(h));
        check({n, " s.code"},   32'(code_s),   32'(code));
    endtask

    task automatic stat_c(input string n, input int m, input int e, input int h, input int code);
        check({n, " c.match"},  32'(match_c),  32'(m));
        check({n, " c.errors"}, 32'(err_c),    32'(e));
        check({n, " c.halted"}, 32'(halted_c), 32'(h));
        check({n, " c.code"},   32'(code_c),   32'(code));
    endtask

    task automatic drained(input string n);
        check({n, " q_s drained"}, 32'(q_s.size()), 32'd0);
        check({n, " q_c drained"}, 32'(q_c.size()), 32'd0);
        q_s.delete();
        q_c.delete();
    endtask

    task automatic push(input logic k, input logic [15:0] a, input logic [7:0] d);
        exp_valid    = 1'b1;
        exp_is_write = k;
        exp_addr     = a;
        exp_data     = d;
        tick();
        exp_valid    = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input int n, input logic [7:0] d,
                            input logic exp_oe_s, input logic exp_oe_c);
        nsel        = 1'b0;
        nread       = 1'b0;
        address_bus = a;
        for (int i = 0; i < n; i++) begin
            if (exp_oe_s) q_s.push_back(d);
            if (exp_oe_c) q_c.push_back(d);
            tick();
        end
        nsel  = 1'b1;
        nread = 1'b1;
        tick();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        nsel        = 1'b0;
        nwrite      = 1'b0;
        address_bus = a;
        data_in     = d;
        tick();
        nsel   = 1'b1;
        nwrite = 1'b1;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        exp_valid = 1'b0; exp_is_write = 1'b0; exp_addr = '0; exp_data = '0;
        address_bus = '0; data_in = '0;
        nread = 1'b1; nwrite = 1'b1; nsel = 1'b1;
        #2 reset = 1'b0;
        tick(); tick();

        // Reset state
        stat_s("reset", 0, 0, 0, 0);
        stat_c("reset", 0, 0, 0, 0);
        check("reset s.ready", 32'(ready_s), 32'd1);
        check("reset s.oe", 32'(oe_s), 32'd0);
        check("reset s.index", 32'(idx_s), 32'd0);
        reset = 1'b1;
        tick();

        // Read served for three cycles, then a matching write
        push(1'b0, 16'h0100, 8'h3E);
        push(1'b1, 16'hFF40, 8'h91);
        cpu_read(16'h0100, 3, 8'h3E, 1'b1, 1'b1);
        cpu_write(16'hFF40, 8'h91);
        stat_s("t1", 2, 0, 0, 0);
        stat_c("t1", 2, 0, 0, 0);
        drained("t1");

        // Empty FIFO read -> underflow; then both strobes at once
        cpu_read(16'h0100, 1, 8'h00, 1'b0, 1'b0);
        stat_s("uflow", 2, 1, 1, 4);
        stat_c("uflow", 2, 1, 0, 4);
        check("uflow s.index", 32'(idx_s), 32'd2);
        check("uflow c.got_addr", 32'(gaddr_c), 32'h0100);
        nsel = 1'b0; nread = 1'b0; nwrite = 1'b0; address_bus = 16'h0100;
        tick();
        nsel = 1'b1; nread = 1'b1; nwrite = 1'b1;
        tick();
        stat_s("both", 2, 1, 1, 4);
        stat_c("both", 2, 2, 0, 4);
        check("both c.index", 32'(idx_c), 32'd2);
        drained("uflow");

        // Clear flushes everything
        do_clear();
        stat_s("clear", 0, 0, 0, 0);
        stat_c("clear", 0, 0, 0, 0);
        check("clear s.index", 32'(idx_s), 32'd0);

        // Write data mismatch
        push(1'b1, 16'hC000, 8'h55);
        cpu_write(16'hC000, 8'h54);
        stat_s("wdata", 0, 1, 1, 2);
        stat_c("wdata", 0, 1, 0, 2);
        check("wdata s.exp_data", 32'(edata_s), 32'h55);
        check("wdata s.got_data", 32'(gdata_s), 32'h54);
        check("wdata s.index", 32'(idx_s), 32'd0);
        check("wdata s.exp_addr", 32'(eaddr_s), 32'hC000);
        check("wdata c.got_data", 32'(gdata_c), 32'h54);
        push(1'b0, 16'h1234, 8'hA5);
        cpu_read(16'h1234, 2, 8'hA5, 1'b0, 1'b1);
        stat_s("halted", 0, 1, 1, 2);
        stat_c("halted", 1, 1, 0, 2);
        drained("wdata");

        // Address mismatch, then a match on the next entry
        do_clear();
        push(1'b0, 16'h0000, 8'h11);
        push(1'b0, 16'h0001, 8'h22);
        cpu_read(16'h0002, 1, 8'h11, 1'b1, 1'b1);
        cpu_read(16'h0001, 1, 8'h22, 1'b0, 1'b1);
        stat_s("addr", 0, 1, 1, 1);
        stat_c("addr", 1, 1, 0, 1);
        check("addr c.exp_addr", 32'(eaddr_c), 32'h0000);
        check("addr c.got_addr", 32'(gaddr_c), 32'h0002);
        check("addr c.index", 32'(idx_c), 32'd0);
        drained("addr");

        // FIFO full / back-pressure / simultaneous push and pop
        do_clear();
        exp_valid = 1'b1;
        exp_is_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_addr = 16'h0A00 + 16'(i);
            exp_data = 8'hD0 + 8'(i);
            tick();
            check($sformatf("fill%0d s.ready", i), 32'(ready_s), (i < 3) ? 32'd1 : 32'd0);
        end
        check("fill c.ready", 32'(ready_c), 32'd0);
        exp_addr = 16'h0A04;
        exp_data = 8'hD4;
        tick();
        check("full hold s.ready", 32'(ready_s), 32'd0);
        cpu_read(16'h0A00, 1, 8'hD0, 1'b1, 1'b1);
        check("after pop s.ready", 32'(ready_s), 32'd1);
        tick();
        check("refill s.ready", 32'(ready_s), 32'd0);
        check("refill c.ready", 32'(ready_c), 32'd0);
        exp_valid = 1'b0;
        cpu_read(16'h0A01, 1, 8'hD1, 1'b1, 1'b1);
        check("three s.ready", 32'(ready_s), 32'd1);
        nsel = 1'b0; nread = 1'b0; address_bus = 16'h0A02;
        q_s.push_back(8'hD2); q_c.push_back(8'hD2);
        tick();
        nsel = 1'b1; nread = 1'b1;
        exp_valid = 1'b1; exp_addr = 16'h0A05; exp_data = 8'hD5;
        tick();
        exp_valid = 1'b0;
        check("push+pop s.ready", 32'(ready_s), 32'd1);
        push(1'b0, 16'h0A06, 8'hD6);
        check("push+pop full s.ready", 32'(ready_s), 32'd0);
        check("push+pop full c.ready", 32'(ready_c), 32'd0);
        for (int i = 3; i < 7; i++) begin
            cpu_read(16'h0A00 + 16'(i), 1, 8'hD0 + 8'(i), 1'b1, 1'b1);
        end
        stat_s("fifo", 7, 0, 0, 0);
        stat_c("fifo", 7, 0, 0, 0);
        check("fifo s.ready", 32'(ready_s), 32'd1);
        drained("fifo");

        // Asynchronous reset in the middle of a read access
        push(1'b0, 16'h0BEE, 8'h77);
        nsel = 1'b0; nread = 1'b0; address_bus = 16'h0BEE;
        q_s.push_back(8'h77); q_c.push_back(8'h77);
        tick();
        #1 reset = 1'b0;
        #1;
        check("areset s.oe", 32'(oe_s), 32'd0);
        check("areset c.oe", 32'(oe_c), 32'd0);
        check("areset s.match", 32'(match_s), 32'd0);
        check("areset c.match", 32'(match_c), 32'd0);
        check("areset s.ready", 32'(ready_s), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        stat_s("post-reset", 0, 1, 1, 4);
        stat_c("post-reset", 0, 1, 0, 4);
        nsel = 1'b1; nread = 1'b1;
        tick();
        drained("areset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
